// File: rtl/pid_pkg.sv
// Shared definitions for the PID datapath: default widths, default
// derivative gain and a generic signed clamp used by the P, I and D terms.
package pid_pkg;

  localparam int ERR_W_DFLT  = 10;
  localparam int DIFF_W_DFLT = 7;
  localparam int GAIN_W_DFLT = 5;

  localparam logic [GAIN_W_DFLT-1:0] D_GAIN_DFLT = 5'd7;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  // Callers truncate the result to 'width' bits; the clamp guarantees the
  // truncation is lossless.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/dterm_hist.sv
// One channel's sample history: a DEPTH-entry shift queue plus a saturating
// fill counter that reports when the queue holds DEPTH real samples.
module dterm_hist #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift,
  input  logic                clr,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] oldest,
  output logic                primed
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  logic signed [W-1:0] q_q [DEPTH];
  logic [FILL_W-1:0]   fill_q;

  // Queue shift on accepted samples; clear wipes the history back to zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else if (shift) begin
      q_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) q_q[i] <= q_q[i-1];
    end
  end

  // Fill counter saturates at DEPTH so 'primed' stays set until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else if (clr) begin
      fill_q <= '0;
    end else if (shift && (fill_q != FILL_W'(DEPTH))) begin
      fill_q <= fill_q + FILL_W'(1);
    end
  end

  assign oldest = q_q[DEPTH-1];
  assign primed = (fill_q == FILL_W'(DEPTH));

endmodule

// File: rtl/dterm_mc.sv
// Multi-channel derivative term: D = sat(err - err[n-DEPTH]) * d_gain.
// Two register stages: stage 1 holds the clamped difference, stage 2 the
// product. Each channel keeps its own history; out-of-range channels are
// ignored entirely.
module dterm_mc
  import pid_pkg::*;
#(
  parameter  int ERR_W  = ERR_W_DFLT,
  parameter  int DIFF_W = DIFF_W_DFLT,
  parameter  int GAIN_W = GAIN_W_DFLT,
  parameter  int DEPTH  = 2,
  parameter  int NUM_CH = 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int D_W    = DIFF_W + GAIN_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    err_vld,
  input  logic [CH_W-1:0]         err_ch,
  input  logic [GAIN_W-1:0]       d_gain,
  input  logic                    clr,
  output logic signed [D_W-1:0]   D_term,
  output logic                    D_vld,
  output logic [CH_W-1:0]         D_ch
);

  logic                     ch_ok;
  logic                     accept;
  logic [NUM_CH-1:0]        shift_w;
  logic [NUM_CH-1:0]        primed_w;
  logic signed [ERR_W-1:0]  oldest_w [NUM_CH];

  logic signed [ERR_W-1:0]  oldest_sel;
  logic                     primed_sel;
  logic signed [ERR_W:0]    diff_wide;
  logic signed [31:0]       diff_ext;
  logic signed [DIFF_W-1:0] diff_sat_d;
  logic signed [D_W-1:0]    prod_d;

  logic                     s1_vld_q;
  logic signed [DIFF_W-1:0] s1_diff_q;
  logic [CH_W-1:0]          s1_ch_q;

  logic                     d_vld_q;
  logic signed [D_W-1:0]    d_term_q;
  logic [CH_W-1:0]          d_ch_q;

  assign ch_ok  = (32'(err_ch) < 32'(NUM_CH));
  assign accept = err_vld && ch_ok && !clr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign shift_w[g] = accept && (32'(err_ch) == 32'(g));

    dterm_hist #(
      .W     (ERR_W),
      .DEPTH (DEPTH)
    ) u_hist (
      .clk    (clk),
      .rst_n  (rst_n),
      .shift  (shift_w[g]),
      .clr    (clr),
      .din    (err_sat),
      .oldest (oldest_w[g]),
      .primed (primed_w[g])
    );
  end

  // Select the addressed channel's oldest sample and primed flag.
  always_comb begin
    oldest_sel = '0;
    primed_sel = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(err_ch) == 32'(c)) begin
        oldest_sel = oldest_w[c];
        primed_sel = primed_w[c];
      end
    end
  end

  // Difference one bit wider than the inputs cannot wrap; clamp it, and
  // force zero while the channel history is still warming up.
  always_comb begin
    diff_wide  = $signed({err_sat[ERR_W-1], err_sat}) -
                 $signed({oldest_sel[ERR_W-1], oldest_sel});
    diff_ext   = 32'(diff_wide);
    diff_sat_d = '0;
    if (primed_sel) begin
      diff_sat_d = DIFF_W'(sat_signed(diff_ext, DIFF_W));
    end
  end

  // Unsigned gain is zero-extended to a signed operand; D_W bits hold the
  // full product range, so no further clamp is needed.
  always_comb begin
    prod_d = D_W'(s1_diff_q) * D_W'($signed({1'b0, d_gain}));
  end

  // Stage 1: clamped difference and channel tag of the accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s1_ch_q   <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_diff_q <= diff_sat_d;
        s1_ch_q   <= err_ch;
      end
    end
  end

  // Stage 2: product and tag; a clear while a sample is in stage 1 kills it,
  // and the result/tag registers hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_vld_q  <= 1'b0;
      d_term_q <= '0;
      d_ch_q   <= '0;
    end else begin
      d_vld_q <= s1_vld_q && !clr;
      if (s1_vld_q && !clr) begin
        d_term_q <= prod_d;
        d_ch_q   <= s1_ch_q;
      end
    end
  end

  assign D_term = d_term_q;
  assign D_vld  = d_vld_q;
  assign D_ch   = d_ch_q;

endmodule
